// File: rtl/alu_multicycle_pkg.sv
// Shared op codes, FSM encoding and op classification for alu_multicycle.
package alu_pkg;

   localparam logic [31:0] OP_AND  = 32'd0;
   localparam logic [31:0] OP_OR   = 32'd1;
   localparam logic [31:0] OP_ADD  = 32'd2;
   localparam logic [31:0] OP_SUB  = 32'd6;
   localparam logic [31:0] OP_SLT  = 32'd7;
   localparam logic [31:0] OP_MUL  = 32'd8;
   localparam logic [31:0] OP_DIVU = 32'd10;
   localparam logic [31:0] OP_REMU = 32'd11;
   localparam logic [31:0] OP_NOR  = 32'd12;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   // True for the ops that run through the iterative datapath.
   function automatic logic is_multicycle(input logic [31:0] ctrl);
      return (ctrl == OP_MUL) || (ctrl == OP_DIVU) || (ctrl == OP_REMU);
   endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// The first iteration is applied at the start edge, so the last of the
// WIDTH iterations completes WIDTH-1 cycles later; lo_o/rem_o present the
// value the current iteration produces so the caller can register it.
module alu_iter_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             is_div_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] rem_o,
   output logic             done_o
);

   localparam int CNT_W = $clog2(WIDTH);

   // acc holds {partial product high, multiplier} for MUL, quotient in the low half for DIV
   logic [2*WIDTH-1:0] acc_q, acc_d, acc_cur;
   logic [WIDTH:0]     rem_q, rem_d, rem_cur;
   logic [WIDTH-1:0]   b_q, b_cur;
   logic               is_div_q, is_div_cur;
   logic               busy_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH:0]     mul_sum, rem_shift, rem_diff;

   // One iteration step, taken from fresh operands on start or from the registers otherwise
   always_comb begin
      acc_cur    = start_i ? {{WIDTH{1'b0}}, a_i} : acc_q;
      rem_cur    = start_i ? '0 : rem_q;
      b_cur      = start_i ? b_i : b_q;
      is_div_cur = start_i ? is_div_i : is_div_q;
      mul_sum    = {1'b0, acc_cur[2*WIDTH-1:WIDTH]} + (acc_cur[0] ? {1'b0, b_cur} : '0);
      rem_shift  = {rem_cur[WIDTH-1:0], acc_cur[WIDTH-1]};
      rem_diff   = rem_shift - {1'b0, b_cur};
      acc_d      = acc_cur;
      rem_d      = rem_cur;
      if (is_div_cur) begin
         // A zero divisor never borrows, giving all-ones quotient and remainder = dividend
         if (!rem_diff[WIDTH]) begin
            rem_d              = rem_diff;
            acc_d[WIDTH-1:0]   = {acc_cur[WIDTH-2:0], 1'b1};
         end else begin
            rem_d              = rem_shift;
            acc_d[WIDTH-1:0]   = {acc_cur[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_d = {mul_sum, acc_cur[WIDTH-1:1]};
      end
   end

   assign lo_o   = acc_d[WIDTH-1:0];
   assign rem_o  = rem_d[WIDTH-1:0];
   assign done_o = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

   // Iteration registers and counter
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q    <= '0;
         rem_q    <= '0;
         b_q      <= '0;
         is_div_q <= 1'b0;
         busy_q   <= 1'b0;
         cnt_q    <= '0;
      end else if (start_i) begin
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         b_q      <= b_i;
         is_div_q <= is_div_i;
         busy_q   <= 1'b1;
         cnt_q    <= CNT_W'(1);
      end else if (busy_q) begin
         acc_q <= acc_d;
         rem_q <= rem_d;
         if (done_o) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative MUL/DIVU/REMU
// behind a valid/ready accept handshake, with registered result and flags.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [WIDTH-1:0]  src1_i,
   input  logic [WIDTH-1:0]  src2_i,
   output logic              valid_o,
   output logic [WIDTH-1:0]  result_o,
   output logic              zero_o,
   output logic              ovf_o
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             valid_q, valid_d;
   logic             is_rem_q, is_rem_d;
   logic [31:0]      op;
   logic             accept;
   logic [WIDTH-1:0] sum, diff, sc_result;
   logic             sc_ovf;
   logic             md_start, md_done;
   logic [WIDTH-1:0] md_lo, md_rem;

   assign op      = 32'(ctrl_i);
   assign ready_o = (state_q == ST_IDLE);
   assign accept  = valid_i && ready_o;

   // Single-cycle result and signed overflow for the incoming operands
   always_comb begin
      sum       = src1_i + src2_i;
      diff      = src1_i - src2_i;
      sc_result = '0;
      sc_ovf    = 1'b0;
      case (op)
         OP_AND: sc_result = src1_i & src2_i;
         OP_OR:  sc_result = src1_i | src2_i;
         OP_NOR: sc_result = ~(src1_i | src2_i);
         OP_ADD: begin
            sc_result = sum;
            sc_ovf    = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
         end
         OP_SUB: begin
            sc_result = diff;
            sc_ovf    = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (diff[WIDTH-1] != src1_i[WIDTH-1]);
         end
         OP_SLT: sc_result = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
         default: ;
      endcase
   end

   alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (md_start),
      .is_div_i (op != OP_MUL),
      .a_i      (src1_i),
      .b_i      (src2_i),
      .lo_o     (md_lo),
      .rem_o    (md_rem),
      .done_o   (md_done)
   );

   // Next state, output register loads and datapath start
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      valid_d  = 1'b0;
      is_rem_d = is_rem_q;
      md_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (is_multicycle(op)) begin
                  md_start = 1'b1;
                  is_rem_d = (op == OP_REMU);
                  state_d  = ST_BUSY;
               end else begin
                  result_d = sc_result;
                  ovf_d    = sc_ovf;
                  valid_d  = 1'b1;
               end
            end
         end
         ST_BUSY: begin
            if (md_done) begin
               result_d = is_rem_q ? md_rem : md_lo;
               ovf_d    = 1'b0;
               valid_d  = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      zero_d = (result_d == '0);
   end

   // State and output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         zero_q   <= 1'b1;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
         is_rem_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
         is_rem_q <= is_rem_d;
      end
   end

   assign valid_o  = valid_q;
   assign result_o = result_q;
   assign zero_o   = zero_q;
   assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: a 32-bit and an 8-bit instance, each checked every
// cycle against a transaction-level reference model, plus directed literals.
module tb_alu_multicycle;
   import alu_pkg::*;

   typedef struct {
      int          due;
      logic [63:0] res;
      bit          ovf;
   } exp_t;

   logic              clk;
   logic              rst;
   logic [1:0]        v_i;
   logic [31:0]       ctl [2];
   logic [63:0]       s1 [2];
   logic [63:0]       s2 [2];
   logic [1:0]        vo, rdy, zv, ovv, mdl_ready;
   logic [1:0][63:0]  res;
   int                checks = 0;
   int                errors = 0;
   logic [31:0]       ops [11] = '{32'd0, 32'd1, 32'd2, 32'd6, 32'd7, 32'd12,
                                   32'd8, 32'd10, 32'd11, 32'd3, 32'd15};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // ---------------- reference model (plain arithmetic) ----------------
   function automatic logic [63:0] wmask(int w);
      return (64'd1 << w) - 64'd1;
   endfunction

   function automatic longint sval(int w, logic [63:0] x);
      longint v = longint'(x);
      if (x[w-1]) v = v - (longint'(1) << w);
      return v;
   endfunction

   function automatic logic [63:0] ref_res(int w, logic [31:0] op, logic [63:0] a0, logic [63:0] b0);
      logic [63:0] m = wmask(w);
      logic [63:0] a = a0 & m;
      logic [63:0] b = b0 & m;
      case (op)
         32'd0:   return a & b;
         32'd1:   return a | b;
         32'd12:  return ~(a | b) & m;
         32'd2:   return (a + b) & m;
         32'd6:   return (a - b) & m;
         32'd7:   return (sval(w, a) < sval(w, b)) ? 64'd1 : 64'd0;
         32'd8:   return (a * b) & m;
         32'd10:  return (b == 0) ? m : a / b;
         32'd11:  return (b == 0) ? a : a % b;
         default: return 64'd0;
      endcase
   endfunction

   function automatic bit ref_ovf(int w, logic [31:0] op, logic [63:0] a0, logic [63:0] b0);
      longint a = sval(w, a0 & wmask(w));
      longint b = sval(w, b0 & wmask(w));
      longint mx = (longint'(1) << (w - 1)) - 1;
      longint mn = -(longint'(1) << (w - 1));
      longint r;
      if (op == 32'd2)      r = a + b;
      else if (op == 32'd6) r = a - b;
      else return 1'b0;
      return (r > mx) || (r < mn);
   endfunction

   function automatic bit is_long(logic [31:0] op);
      return (op == 32'd8) || (op == 32'd10) || (op == 32'd11);
   endfunction

   // ---------------- DUT instances with per-instance model and compare ----------------
   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int W = (gi == 0) ? 32 : 8;
      logic [W-1:0] r;
      logic         rdy_l, vo_l, z_l, ov_l;
      exp_t         q [$];
      exp_t         e;
      int           ready_from;
      int           mcyc;
      logic [63:0]  held_res;
      bit           held_ovf;
      bit           ev;

      alu_multicycle #(.WIDTH(W), .CTRL_W(4)) u_dut (
         .clk_i    (clk),
         .rst_i    (rst),
         .valid_i  (v_i[gi]),
         .ready_o  (rdy_l),
         .ctrl_i   (ctl[gi][3:0]),
         .src1_i   (s1[gi][W-1:0]),
         .src2_i   (s2[gi][W-1:0]),
         .valid_o  (vo_l),
         .result_o (r),
         .zero_o   (z_l),
         .ovf_o    (ov_l)
      );

      assign vo[gi]        = vo_l;
      assign rdy[gi]       = rdy_l;
      assign zv[gi]        = z_l;
      assign ovv[gi]       = ov_l;
      assign res[gi]       = 64'(r);
      assign mdl_ready[gi] = (mcyc >= ready_from);

      // Model: record accepted requests at each rising edge
      initial begin
         ready_from = 0;
         mcyc       = 0;
         held_res   = '0;
         held_ovf   = 1'b0;
         forever begin
            @(posedge clk);
            if (rst) begin
               q.delete();
               ready_from = mcyc + 1;
               held_res   = '0;
               held_ovf   = 1'b0;
            end else if (v_i[gi] && mcyc >= ready_from) begin
               e.res = ref_res(W, ctl[gi], s1[gi], s2[gi]);
               e.ovf = ref_ovf(W, ctl[gi], s1[gi], s2[gi]);
               if (is_long(ctl[gi])) begin
                  e.due      = mcyc + W;
                  ready_from = mcyc + W;
               end else begin
                  e.due = mcyc + 1;
               end
               q.push_back(e);
            end
            mcyc++;
         end
      end

      // Compare: every cycle, away from the active edge
      initial begin
         forever begin
            @(negedge clk);
            if (mcyc >= 1) begin
               ev = (q.size() > 0) && (q[0].due == mcyc);
               if (ev) begin
                  held_res = q[0].res;
                  held_ovf = q[0].ovf;
                  void'(q.pop_front());
               end
               chk((gi == 0) ? "valid32"  : "valid8",  64'(vo_l),  64'(ev));
               chk((gi == 0) ? "ready32"  : "ready8",  64'(rdy_l), 64'(mcyc >= ready_from));
               chk((gi == 0) ? "result32" : "result8", 64'(r),     held_res);
               chk((gi == 0) ? "zero32"   : "zero8",   64'(z_l),   64'(held_res == 0));
               chk((gi == 0) ? "ovf32"    : "ovf8",    64'(ov_l),  64'(held_ovf));
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic issue(input int k, input logic [31:0] op, input logic [63:0] a, input logic [63:0] b);
      int n = 0;
      while (!mdl_ready[k] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!mdl_ready[k]) chk("ready_timeout", 64'(n), 64'd0);
      v_i[k] = 1'b1;
      ctl[k] = op;
      s1[k]  = a;
      s2[k]  = b;
      @(negedge clk);
      v_i[k] = 1'b0;
      $display("op k=%0d ctrl=%0d a=%0h b=%0h", k, op, a, b);
   endtask

   task automatic wait_valid(input int k, output int n);
      n = 0;
      while (!vo[k] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!vo[k]) chk("valid_timeout", 64'(n), 64'd0);
   endtask

   function automatic logic [63:0] rnd_opnd(int w);
      logic [63:0] m = wmask(w);
      case ($urandom_range(0, 5))
         0:       return 64'd0;
         1:       return m;
         2:       return 64'd1 << (w - 1);
         3:       return 64'($urandom_range(0, 15));
         default: return {$urandom(), $urandom()} & m;
      endcase
   endfunction

   initial begin
      int n;
      int stale;
      rst = 1'b1;
      v_i = '0;
      for (int k = 0; k < 2; k++) begin
         ctl[k] = '0;
         s1[k]  = '0;
         s2[k]  = '0;
      end
      repeat (3) @(negedge clk);
      chk("reset_result", res[0], 64'd0);
      chk("reset_zero", 64'(zv[0]), 64'd1);
      chk("reset_ready", 64'(rdy[0]), 64'd1);
      rst = 1'b0;

      // Hand-computed pins on the model itself
      chk("pin_mul", ref_res(32, OP_MUL, 64'h0001_0003, 64'd5), 64'h0005_000F);
      chk("pin_divz", ref_res(32, OP_DIVU, 64'h1234, 64'd0), 64'hFFFF_FFFF);
      chk("pin_slt", ref_res(32, OP_SLT, 64'hFFFF_FFFF, 64'd1), 64'd1);
      chk("pin_ovf", 64'(ref_ovf(32, OP_ADD, 64'h7FFF_FFFF, 64'd1)), 64'd1);
      chk("pin_mul8", ref_res(8, OP_MUL, 64'hFF, 64'hFF), 64'd1);

      // Back-to-back single-cycle ops
      issue(0, OP_ADD, 64'h7FFF_FFFF, 64'd1);
      chk("add_res", res[0], 64'h8000_0000);
      chk("add_ovf", 64'(ovv[0]), 64'd1);
      chk("add_valid", 64'(vo[0]), 64'd1);
      issue(0, OP_SUB, 64'd5, 64'd5);
      chk("sub_res", res[0], 64'd0);
      chk("sub_zero", 64'(zv[0]), 64'd1);
      chk("sub_ovf", 64'(ovv[0]), 64'd0);
      chk("sub_valid", 64'(vo[0]), 64'd1);
      issue(0, OP_SLT, 64'hFFFF_FFFF, 64'd1);
      chk("slt_res", res[0], 64'd1);
      chk("slt_valid", 64'(vo[0]), 64'd1);

      // MUL latency
      issue(0, OP_MUL, 64'h0001_0003, 64'd5);
      wait_valid(0, n);
      chk("mul_latency", 64'(n), 64'd31);
      chk("mul_res", res[0], 64'h0005_000F);

      // DIVU with input churn and ignored requests while busy
      issue(0, OP_DIVU, 64'd100, 64'd7);
      for (int i = 0; i < 4; i++) begin
         v_i[0] = 1'b1;
         ctl[0] = OP_ADD;
         s1[0]  = 64'($urandom());
         s2[0]  = 64'($urandom());
         @(negedge clk);
      end
      v_i[0] = 1'b0;
      wait_valid(0, n);
      chk("divu_res", res[0], 64'd14);
      issue(0, OP_REMU, 64'd100, 64'd7);
      wait_valid(0, n);
      chk("remu_res", res[0], 64'd2);
      issue(0, OP_DIVU, 64'h1234, 64'd0);
      wait_valid(0, n);
      chk("divu_zero", res[0], 64'hFFFF_FFFF);
      issue(0, OP_REMU, 64'd9, 64'd0);
      wait_valid(0, n);
      chk("remu_zero", res[0], 64'd9);

      // Reset during a MUL
      issue(0, OP_MUL, 64'h1234_5678, 64'h9ABC_DEF0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_result", res[0], 64'd0);
      chk("rst_zero", 64'(zv[0]), 64'd1);
      chk("rst_valid", 64'(vo[0]), 64'd0);
      chk("rst_ready", 64'(rdy[0]), 64'd1);
      stale = 0;
      repeat (40) begin
         @(negedge clk);
         if (vo[0]) stale++;
      end
      chk("rst_no_stale", 64'(stale), 64'd0);

      // WIDTH=8 instance
      issue(1, OP_MUL, 64'hFF, 64'hFF);
      wait_valid(1, n);
      chk("mul8_latency", 64'(n), 64'd7);
      chk("mul8_res", res[1], 64'h01);
      issue(1, OP_DIVU, 64'hFF, 64'h10);
      wait_valid(1, n);
      chk("divu8_res", res[1], 64'h0F);

      // Randomised traffic on both instances
      for (int k = 0; k < 2; k++) begin
         for (int t = 0; t < 150; t++) begin
            issue(k, ops[$urandom_range(0, 10)], rnd_opnd((k == 0) ? 32 : 8), rnd_opnd((k == 0) ? 32 : 8));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            if ($urandom_range(0, 4) == 0) begin
               v_i[k] = 1'b1;
               ctl[k] = ops[$urandom_range(0, 10)];
               s1[k]  = rnd_opnd((k == 0) ? 32 : 8);
               s2[k]  = rnd_opnd((k == 0) ? 32 : 8);
               @(negedge clk);
               v_i[k] = 1'b0;
            end
         end
      end

      repeat (40) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
